// File: rtl/pulse_measure_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_measure_pkg
// Description : Shared widths, saturation limits, FSM state encoding and
//               saturating-increment helpers for pulse_measure.
// Contents    : CNT_W / REP_W widths, CNT_MAX / REP_MAX limits, state_t
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_measure_pkg;

  localparam int CNT_W = 32;
  localparam int REP_W = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [REP_W-1:0] REP_MAX = {REP_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

  function automatic logic [REP_W-1:0] sat_inc_rep(input logic [REP_W-1:0] v);
    return (v == REP_MAX) ? REP_MAX : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_measure_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sync_edge
// Description : 2-FF synchronizer for the asynchronous pulse pin plus one
//               delay register for edge detection.
// Ports       : clk, reset (sync, active-high), pulse_in (async pin)
//               pulse_s (synchronized level), rise, fall (one-cycle strobes,
//               asserted in the cycle pulse_s changes)
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic pulse_in,
  output logic pulse_s,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic pulse_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      pulse_s <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1   <= pulse_in;
      pulse_s <= sync1;
      pulse_q <= pulse_s;
    end
  end

  assign rise = pulse_s & ~pulse_q;
  assign fall = ~pulse_s & pulse_q;

endmodule
`default_nettype wire

// File: rtl/pulse_measure.sv
`default_nettype none
// ============================================================================
// Module      : pulse_measure
// Description : Measures an external pulse train: arm-to-first-rise delay,
//               last pulse width, last rise-to-rise period and pulse count,
//               with optional timeout and abort.
// Config      : `PULSE_MEASURE_MINMAX_EN - when defined, min_width/max_width
//               track width extremes; otherwise both ports are tied to 0.
// Ports       : clk, reset (sync, active-high)
//               arm_in, abort_in, pulse_in (async), expected_count[15:0],
//               timeout_cycles[31:0]
//               arm_ack, busy, done, timed_out, pulse_count[15:0],
//               first_delay, last_width, last_period, min_width, max_width
//               (all [31:0]), level_led, busy_led
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_measure
  import pulse_measure_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             arm_in,
  input  logic             abort_in,
  input  logic             pulse_in,
  input  logic [REP_W-1:0] expected_count,
  input  logic [CNT_W-1:0] timeout_cycles,
  output logic             arm_ack,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [REP_W-1:0] pulse_count,
  output logic [CNT_W-1:0] first_delay,
  output logic [CNT_W-1:0] last_width,
  output logic [CNT_W-1:0] last_period,
  output logic [CNT_W-1:0] min_width,
  output logic [CNT_W-1:0] max_width,
  output logic             level_led,
  output logic             busy_led
);

  logic pulse_s, rise, fall;

  pulse_sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pulse_in),
    .pulse_s  (pulse_s),
    .rise     (rise),
    .fall     (fall)
  );

  state_t state, state_nxt;

  // wait_cnt is 1 in the first cycle of every state; it is the timeout
  // reference in WAIT_RISE/LOW and also yields first_delay.
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] width_cnt;
  logic [CNT_W-1:0] period_cnt;

  logic             accept, complete, tmo, start_pulse, end_pulse;
  logic             tmo_hit, count_hit;
  logic [REP_W-1:0] count_inc;

  assign count_inc = sat_inc_rep(pulse_count);
  assign count_hit = (expected_count != '0) && (count_inc == expected_count);
  assign tmo_hit   = (timeout_cycles != '0) && (wait_cnt == timeout_cycles);

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    complete    = 1'b0;
    tmo         = 1'b0;
    start_pulse = 1'b0;
    end_pulse   = 1'b0;
    if (abort_in) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arm_in) begin
            state_nxt = WAIT_RISE;
            accept    = 1'b1;
          end
        end
        WAIT_RISE, LOW: begin
          // A rise in the timeout cycle takes precedence over the timeout.
          if (rise) begin
            state_nxt   = HIGH;
            start_pulse = 1'b1;
          end else if (tmo_hit) begin
            state_nxt = IDLE;
            tmo       = 1'b1;
          end
        end
        HIGH: begin
          if (fall) begin
            end_pulse = 1'b1;
            if (count_hit) begin
              state_nxt = IDLE;
              complete  = 1'b1;
            end else begin
              state_nxt = LOW;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      arm_ack     <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      wait_cnt    <= '0;
      width_cnt   <= '0;
      period_cnt  <= '0;
      pulse_count <= '0;
      first_delay <= '0;
      last_width  <= '0;
      last_period <= '0;
    end else begin
      state    <= state_nxt;
      arm_ack  <= accept;
      done     <= complete | tmo;
      wait_cnt <= (state_nxt != state) ? CNT_W'(1) : sat_inc_cnt(wait_cnt);

      // Width and period both restart at the rise so that each reads the
      // cycle distance to the next fall / rise detect respectively.
      if (start_pulse) begin
        width_cnt  <= CNT_W'(1);
        period_cnt <= CNT_W'(1);
      end else begin
        width_cnt  <= sat_inc_cnt(width_cnt);
        period_cnt <= sat_inc_cnt(period_cnt);
      end

      if (accept) begin
        timed_out   <= 1'b0;
        pulse_count <= '0;
        first_delay <= '0;
        last_width  <= '0;
        last_period <= '0;
      end
      if (tmo) timed_out <= 1'b1;

      if (start_pulse && state == WAIT_RISE)
        first_delay <= (wait_cnt == CNT_MAX) ? CNT_MAX : wait_cnt - 1'b1;
      if (start_pulse && state == LOW)
        last_period <= period_cnt;
      if (end_pulse) begin
        last_width  <= width_cnt;
        pulse_count <= count_inc;
      end
    end
  end

`ifdef PULSE_MEASURE_MINMAX_EN
  logic [CNT_W-1:0] min_r, max_r;

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      min_r <= CNT_MAX;
      max_r <= '0;
    end else if (end_pulse) begin
      if (width_cnt < min_r) min_r <= width_cnt;
      if (width_cnt > max_r) max_r <= width_cnt;
    end
  end

  assign min_width = min_r;
  assign max_width = max_r;
`else
  assign min_width = '0;
  assign max_width = '0;
`endif

  assign busy      = (state != IDLE);
  assign busy_led  = busy;
  assign level_led = pulse_s;

endmodule
`default_nettype wire

// File: tb/tb_pulse_measure.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_measure
// Description : Self-checking bench for pulse_measure. Directed pulse-train
//               vectors with hand-computed results, plus hand sequences for
//               abort, arm-while-busy and reset mid-measurement.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_measure;

`ifdef PULSE_MEASURE_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, arm_in, abort_in, pulse_in;
  logic [15:0] expected_count;
  logic [31:0] timeout_cycles;
  logic        arm_ack, busy, done, timed_out, level_led, busy_led;
  logic [15:0] pulse_count;
  logic [31:0] first_delay, last_width, last_period, min_width, max_width;

  pulse_measure dut (
    .clk(clk), .reset(reset), .arm_in(arm_in), .abort_in(abort_in),
    .pulse_in(pulse_in), .expected_count(expected_count),
    .timeout_cycles(timeout_cycles), .arm_ack(arm_ack), .busy(busy),
    .done(done), .timed_out(timed_out), .pulse_count(pulse_count),
    .first_delay(first_delay), .last_width(last_width),
    .last_period(last_period), .min_width(min_width), .max_width(max_width),
    .level_led(level_led), .busy_led(busy_led)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    int          d, per, w0, w1, w2, n, hi;   // pin pulses, offsets from arm cycle
    logic [15:0] cnt_cfg;
    logic [31:0] tmo_cfg;
    int          done_off;
    logic [31:0] e_first, e_width, e_period;
    logic [15:0] e_count;
    logic        e_to;
    logic [31:0] e_min, e_max;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pin level in cycle (arm cycle + off): high before 'hi', then n pulses
  // starting at d spaced per apart with widths w0, w1, w2 (w2 repeats).
  function automatic logic pin_at(input int off, input int d, input int per,
                                  input int w0, input int w1, input int w2,
                                  input int n, input int hi);
    if (off < hi) return 1'b1;
    for (int j = 0; j < n; j++) begin
      automatic int w = (j == 0) ? w0 : (j == 1) ? w1 : w2;
      automatic int s = d + j * per;
      if (off >= s && off < s + w) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic arm_now(input logic [15:0] cnt, input logic [31:0] tmo, input string name);
    expected_count = cnt;
    timeout_cycles = tmo;
    arm_in = 1'b1;
    step();
    arm_in = 1'b0;
    chk({name, ".arm_ack"}, 32'(arm_ack), 32'd1);
    chk({name, ".busy"}, 32'(busy), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int ndone, first_off;
    pulse_in = (v.hi > 0);
    for (int i = 0; i < 4; i++) step();
    arm_now(v.cnt_cfg, v.tmo_cfg, v.name);
    ndone = 0;
    first_off = -1;
    for (int off = 1; off <= 110; off++) begin
      pulse_in = pin_at(off, v.d, v.per, v.w0, v.w1, v.w2, v.n, v.hi);
      if (done) begin
        ndone++;
        if (first_off < 0) first_off = off;
      end
      step();
    end
    pulse_in = 1'b0;
    chk({v.name, ".done_count"}, 32'(ndone), 32'd1);
    chk({v.name, ".done_cycle"}, 32'(first_off), 32'(v.done_off));
    chk({v.name, ".first_delay"}, first_delay, v.e_first);
    chk({v.name, ".last_width"}, last_width, v.e_width);
    chk({v.name, ".last_period"}, last_period, v.e_period);
    chk({v.name, ".pulse_count"}, 32'(pulse_count), 32'(v.e_count));
    chk({v.name, ".timed_out"}, 32'(timed_out), 32'(v.e_to));
    chk({v.name, ".min_width"}, min_width, MM ? v.e_min : 32'd0);
    chk({v.name, ".max_width"}, max_width, MM ? v.e_max : 32'd0);
    chk({v.name, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_cleared(input string name);
    chk({name, ".busy"}, 32'(busy), 32'd0);
    chk({name, ".busy_led"}, 32'(busy_led), 32'd0);
    chk({name, ".done"}, 32'(done), 32'd0);
    chk({name, ".arm_ack"}, 32'(arm_ack), 32'd0);
    chk({name, ".timed_out"}, 32'(timed_out), 32'd0);
    chk({name, ".pulse_count"}, 32'(pulse_count), 32'd0);
    chk({name, ".first_delay"}, first_delay, 32'd0);
    chk({name, ".last_width"}, last_width, 32'd0);
    chk({name, ".last_period"}, last_period, 32'd0);
    chk({name, ".min_width"}, min_width, MM ? 32'hFFFF_FFFF : 32'd0);
    chk({name, ".max_width"}, max_width, 32'd0);
  endtask

  initial begin
    int ndone;
    //          name          d   per w0 w1 w2 n  hi  cnt tmo done first wid per cnt to min max
    vecs[0] = '{"loopback",   11, 15, 5, 5, 5, 3, 0,  3,  0,  49,  12,  5,  15, 3,  0, 5, 5};
    vecs[1] = '{"high_at_arm",28, 0,  4, 4, 4, 1, 20, 1,  0,  35,  29,  4,  0,  1,  0, 4, 4};
    vecs[2] = '{"tmo_wait",   0,  0,  0, 0, 0, 0, 0,  0,  50, 51,  0,   0,  0,  0,  1, 32'hFFFF_FFFF, 0};
    vecs[3] = '{"rise_at_tmo",48, 0,  3, 3, 3, 1, 0,  1,  50, 54,  49,  3,  0,  1,  0, 3, 3};
    vecs[4] = '{"widths_375", 5,  15, 3, 7, 5, 3, 0,  3,  0,  43,  6,   5,  15, 3,  0, 3, 7};
    vecs[5] = '{"tmo_low",    5,  0,  4, 4, 4, 1, 0,  0,  10, 22,  6,   4,  0,  1,  1, 4, 4};

    reset = 1'b1; arm_in = 1'b0; abort_in = 1'b0; pulse_in = 1'b0;
    expected_count = '0; timeout_cycles = '0;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    step();
    chk_cleared("reset");
    chk("reset.level_led", 32'(level_led), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Abort in HIGH of pulse 2; an arm attempt while busy must not be acked.
    for (int i = 0; i < 4; i++) step();
    arm_now(16'd5, 32'd0, "abort");
    ndone = 0;
    for (int off = 1; off <= 40; off++) begin
      pulse_in = pin_at(off, 5, 10, 4, 4, 4, 5, 0);
      arm_in   = (off == 10);
      abort_in = (off == 18);
      if (off == 11) chk("abort.arm_while_busy_ack", 32'(arm_ack), 32'd0);
      if (off == 18) chk("abort.level_led", 32'(level_led), 32'd1);
      if (off == 18) chk("abort.busy_before", 32'(busy), 32'd1);
      if (off == 19) chk("abort.busy_after", 32'(busy), 32'd0);
      if (done) ndone++;
      step();
    end
    pulse_in = 1'b0; arm_in = 1'b0; abort_in = 1'b0;
    chk("abort.done_count", 32'(ndone), 32'd0);
    chk("abort.pulse_count", 32'(pulse_count), 32'd1);
    chk("abort.last_width", last_width, 32'd4);
    chk("abort.first_delay", first_delay, 32'd6);

    // Reset asserted while in LOW between pulse 1 and pulse 2.
    for (int i = 0; i < 4; i++) step();
    arm_now(16'd3, 32'd0, "rst_low");
    for (int off = 1; off <= 13; off++) begin
      pulse_in = pin_at(off, 5, 10, 4, 4, 4, 3, 0);
      reset    = (off == 13);
      step();
    end
    reset = 1'b0;
    pulse_in = 1'b0;
    chk_cleared("rst_low");
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
